t02_wb_request_master: RTL

Downstream bus master for the team-02 core's memory path. It takes the single RAM request port (read enable, write enable, address, store data) and runs one Wishbone classic single-word cycle per request toward the SoC bus. It returns the read word and a `busy_o` status that the memory controller uses to decide when an instruction or data access has completed. The block holds exactly one outstanding transaction.

---
 rtl/t02_wb_request_master_if.sv | 21 ++
 rtl/t02_wb_request_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/t02_wb_request_master_if.sv
// rtl/t02_wb_request_master_if.sv - Wishbone classic single-master bus bundle for the team-02 memory path
interface t02_wb_request_master_if;
   logic [31:0] ADR_O;
   logic [31:0] DAT_O;
   logic [3:0]  SEL_O;
   logic        WE_O;
   logic        STB_O;
   logic        CYC_O;
   logic [31:0] DAT_I;
   logic        ACK_I;

   modport master (
      output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
      input  DAT_I, ACK_I
   );

   modport slave (
      input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
      output DAT_I, ACK_I
   );
endinterface

// File: rtl/t02_wb_request_master.sv
// rtl/t02_wb_request_master.sv - one Wishbone classic cycle per RAM request; ACK timeout under T02_WB_TIMEOUT_EN
module t02_wb_request_master #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        Ren,
   input  logic        Wen,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic        busy_o,
   output logic        bus_err,
   t02_wb_request_master_if.master wb
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t state, next_state;
   logic   req;
   logic   start;
   logic   ack_done;
   logic   timeout;
   logic   unused_addr_lsb;

   // Ren=Wen=1 is the controller's idle encoding, so only exactly one asserted counts.
   assign req    = Ren ^ Wen;
   assign busy_o = req & (state != DONE);

   assign unused_addr_lsb = ^ramaddr[1:0];

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      ack_done   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               next_state = BUS;
               start      = 1'b1;
            end
         end
         BUS: begin
            if (wb.ACK_I) begin
               next_state = DONE;
               ack_done   = 1'b1;
            end else if (timeout) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

`ifdef T02_WB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;

   // Fires on the BUS cycle whose closing edge would bring the count to TIMEOUT_CYCLES.
   assign timeout = (state == BUS) && !wb.ACK_I && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         tmo_cnt <= '0;
         bus_err <= 1'b0;
      end else begin
         if (state == BUS && next_state == BUS) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
         bus_err <= timeout;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
   assign bus_err            = 1'b0;
`endif

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         wb.ADR_O <= '0;
         wb.DAT_O <= '0;
         wb.SEL_O <= '0;
         wb.WE_O  <= 1'b0;
         wb.STB_O <= 1'b0;
         wb.CYC_O <= 1'b0;
         ramload  <= '0;
      end else begin
         if (start) begin
            wb.ADR_O <= {ramaddr[31:2], 2'b00};
            wb.DAT_O <= ramstore;
            wb.SEL_O <= 4'hF;
            wb.WE_O  <= Wen;
            wb.STB_O <= 1'b1;
            wb.CYC_O <= 1'b1;
         end else if (ack_done || timeout) begin
            wb.WE_O  <= 1'b0;
            wb.STB_O <= 1'b0;
            wb.CYC_O <= 1'b0;
         end

         // WE_O still holds the latched direction on the terminating cycle.
         if (ack_done && !wb.WE_O) begin
            ramload <= wb.DAT_I;
         end else if (timeout && !wb.WE_O) begin
            ramload <= 32'hBAD0_BAD0;
         end
      end
   end

endmodule
